max31855_emulator: RTL and testbench

SPI responder that emulates the MAX31855 thermocouple-to-digital converter. It is the target side of the existing SPI temperature master and lets the read path run without a physical sensor, either in simulation or looped back on-board. Host logic loads thermocouple temperature, cold-junction temperature and fault flags. On each chip-select assertion the block shifts out the MAX31855 32-bit frame, MSB first, on the master's SPI clock.

---
 rtl/max31855_emulator.sv | 179 +++++++++++++++++
 tb/tb_max31855_emulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/max31855_emulator.sv
// MAX31855 thermocouple converter emulator: SPI target shifting a 32-bit frame.
// Optional: MAX31855_EMU_FAULT_ZERO_EN zeroes the thermocouple field on fault.
module max31855_emulator #(
  parameter int CLK_MIN_RATIO = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPI_clk,
  input  logic        SPI_cs,
  output logic        SPI_Data_Out,
  output logic        SPI_Data_Oe,
  input  logic [13:0] tc_temp,
  input  logic [11:0] cj_temp,
  input  logic        fault_oc,
  input  logic        fault_scg,
  input  logic        fault_scv,
  input  logic        load,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic        cs_fall_q, cs_fall_d;
  logic        cs_rise_q, cs_rise_d;
  logic        sclk_fall_q, sclk_fall_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [28:0] hold_q, hold_d;
  logic [28:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic [28:0] ld_vec;

  assign ld_vec = {tc_temp, cj_temp, fault_scv, fault_scg, fault_oc};

  function automatic logic [31:0] frame_of(input logic [28:0] h);
    logic [13:0] tc;
    logic        flt;
    tc  = h[28:15];
    flt = |h[2:0];
`ifdef MAX31855_EMU_FAULT_ZERO_EN
    if (flt) tc = '0;
`endif
    return {tc, 1'b0, flt, h[14:3], 1'b0, h[2:0]};
  endfunction

  always_comb begin
    cs_sync_d   = {cs_sync_q[1:0], SPI_cs};
    sclk_sync_d = {sclk_sync_q[1:0], SPI_clk};
    cs_fall_d   = cs_sync_q[2] & ~cs_sync_q[1];
    cs_rise_d   = ~cs_sync_q[2] & cs_sync_q[1];
    sclk_fall_d = sclk_sync_q[2] & ~sclk_sync_q[1];
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    // A frame in flight is frozen; loads wait until CS rises.
    if (load) begin
      if (state_q == IDLE) begin
        hold_d = ld_vec;
      end else begin
        pend_d   = ld_vec;
        pend_v_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d = SHIFT;
          shreg_d = frame_of(hold_d);
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (sclk_fall_q) begin
          shreg_d = {shreg_q[30:0], 1'b0};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = DONE;
        end
      end
      DONE: begin
        if (cs_rise_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_d == IDLE && pend_v_d) begin
      hold_d   = pend_d;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cs_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_fall_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
      sclk_fall_q <= sclk_fall_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign SPI_Data_Out = (state_q == SHIFT) & shreg_q[31];
  assign SPI_Data_Oe  = (state_q != IDLE);
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;

`ifndef SYNTHESIS
  logic [7:0] ph_cnt_q, ph_cnt_d;
  logic       sclk_edge;

  assign sclk_edge = sclk_sync_q[2] ^ sclk_sync_q[1];

  always_comb begin
    ph_cnt_d = ph_cnt_q;
    if (sclk_edge) ph_cnt_d = '0;
    else if (ph_cnt_q != 8'hFF) ph_cnt_d = ph_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) ph_cnt_q <= 8'hFF;
    else ph_cnt_q <= ph_cnt_d;
  end

  // SCLK phases shorter than half the ratio outrun the synchronizer.
  always_ff @(posedge clk) begin
    if (!reset && sclk_edge && !cs_sync_q[2])
      assert (int'(ph_cnt_q) + 1 >= CLK_MIN_RATIO / 2)
      else $error("SCLK phase too short: %0d clk", int'(ph_cnt_q) + 1);
  end
`endif

endmodule

// File: tb/tb_max31855_emulator.sv
// Self-checking bench for max31855_emulator: vector table plus corner sequences.
// Expected frames follow MAX31855_EMU_FAULT_ZERO_EN like the design.
module tb_max31855_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        SPI_clk;
  logic        SPI_cs;
  logic        SPI_Data_Out;
  logic        SPI_Data_Oe;
  logic [13:0] tc_temp;
  logic [11:0] cj_temp;
  logic        fault_oc;
  logic        fault_scg;
  logic        fault_scv;
  logic        load;
  logic        frame_done;
  logic        frame_abort;

  always #5 clk = ~clk;

  max31855_emulator #(.CLK_MIN_RATIO(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .SPI_clk      (SPI_clk),
    .SPI_cs       (SPI_cs),
    .SPI_Data_Out (SPI_Data_Out),
    .SPI_Data_Oe  (SPI_Data_Oe),
    .tc_temp      (tc_temp),
    .cj_temp      (cj_temp),
    .fault_oc     (fault_oc),
    .fault_scg    (fault_scg),
    .fault_scv    (fault_scv),
    .load         (load),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort)
  );

  typedef struct {
    logic        do_load;
    logic [13:0] tc;
    logic [11:0] cj;
    logic        oc;
    logic        scg;
    logic        scv;
    int          nbits;
    logic [31:0] frame;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;

`ifdef MAX31855_EMU_FAULT_ZERO_EN
  localparam logic [31:0] F_OC  = 32'h00010001;
  localparam logic [31:0] F_SCV = 32'h00017FF4;
`else
  localparam logic [31:0] F_OC  = 32'h01910001;
  localparam logic [31:0] F_SCV = 32'h7FFD7FF4;
`endif

  always @(posedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [13:0] tc, input logic [11:0] cj,
                         input logic oc, input logic scg, input logic scv);
    @(negedge clk);
    tc_temp = tc; cj_temp = cj;
    fault_oc = oc; fault_scg = scg; fault_scv = scv;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic logic [63:0] exp_bits(input logic [31:0] f,
                                           input int n);
    logic [63:0] w;
    w = {32'h0, f};
    if (n <= 32) return w >> (32 - n);
    return w << (n - 32);
  endfunction

  // Master: drives SCLK with 5-clk phases, samples MISO at each rise.
  task automatic spi_frame(input int nbits, input int load_bit,
                           output logic [63:0] rx, output logic oe_ok);
    rx = '0;
    oe_ok = 1'b1;
    @(negedge clk);
    SPI_cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SPI_clk = 1'b1;
      rx = {rx[62:0], SPI_Data_Out};
      oe_ok &= SPI_Data_Oe;
      if (i == load_bit) begin
        tc_temp = 14'h0001; cj_temp = 12'h000;
        fault_oc = 0; fault_scg = 0; fault_scv = 0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      SPI_clk = 1'b0;
      repeat (5) @(negedge clk);
    end
    SPI_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int nbits,
                           input int load_bit, input logic [31:0] f);
    logic [63:0] rx, exp;
    logic        oe_ok;
    int          d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    exp_q.push_back(exp_bits(f, nbits));
    spi_frame(nbits, load_bit, rx, oe_ok);
    exp = exp_q.pop_front();
    check({name, ".data"}, rx, exp);
    check({name, ".oe"}, 64'(oe_ok), 64'd1);
    check({name, ".done"}, 64'(done_cnt - d0), (nbits >= 32) ? 64'd1 : 64'd0);
    check({name, ".abort"}, 64'(abort_cnt - a0), (nbits < 32) ? 64'd1 : 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 14'h0064, 12'h190, 0, 0, 0, 32, 32'h01901900};
    vecs[1] = '{1'b1, 14'h3FFF, 12'hFFF, 0, 0, 0, 32, 32'hFFFCFFF0};
    vecs[2] = '{1'b1, 14'h0064, 12'h000, 1, 0, 0, 32, F_OC};
    vecs[3] = '{1'b1, 14'h1FFF, 12'h7FF, 0, 0, 1, 32, F_SCV};
    vecs[4] = '{1'b1, 14'h0000, 12'h001, 0, 1, 0, 32, 32'h00010012};
    vecs[5] = '{1'b1, 14'h0064, 12'h190, 0, 0, 0, 10, 32'h01901900};
    vecs[6] = '{1'b0, 14'h0000, 12'h000, 0, 0, 0, 32, 32'h01901900};
    vecs[7] = '{1'b0, 14'h0000, 12'h000, 0, 0, 0, 40, 32'h01901900};

    reset = 1'b1;
    SPI_clk = 1'b0; SPI_cs = 1'b1;
    tc_temp = '0; cj_temp = '0;
    fault_oc = 0; fault_scg = 0; fault_scv = 0;
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("rst.out", 64'(SPI_Data_Out), 64'd0);
    check("rst.oe", 64'(SPI_Data_Oe), 64'd0);
    check("rst.done", 64'(frame_done), 64'd0);
    check("rst.abort", 64'(frame_abort), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_frame("rst_hold", 32, -1, 32'h0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_load)
        do_load(vecs[i].tc, vecs[i].cj, vecs[i].oc, vecs[i].scg, vecs[i].scv);
      run_frame($sformatf("vec%0d", i), vecs[i].nbits, -1, vecs[i].frame);
    end

    do_load(14'h0064, 12'h000, 0, 0, 0);
    run_frame("ld_mid", 32, 5, 32'h01900000);
    run_frame("ld_next", 32, -1, 32'h00040000);

    begin
      int d0, a0;
      do_load(14'h0064, 12'h190, 0, 0, 0);
      d0 = done_cnt;
      a0 = abort_cnt;
      @(negedge clk);
      SPI_cs = 1'b0;
      repeat (5) @(negedge clk);
      repeat (4) begin
        SPI_clk = 1'b1;
        repeat (5) @(negedge clk);
        SPI_clk = 1'b0;
        repeat (5) @(negedge clk);
      end
      check("mid_rst.oe_before", 64'(SPI_Data_Oe), 64'd1);
      reset = 1'b1;
      SPI_cs = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_rst.oe", 64'(SPI_Data_Oe), 64'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_rst.pulses", 64'((done_cnt - d0) + (abort_cnt - a0)), 64'd0);
      run_frame("after_rst", 32, -1, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
